calc_port_responder: RTL and testbench

Single-port responder for the calculator request/response protocol. It accepts a command with its first operand, then the second operand on the following cycle. After a programmable execution delay it returns a response code and a 32-bit result. The block is the responder end of one requester port. Four instances give a four-port calculator, and an instance can also serve as a golden responder alongside the existing calculator benches.

---
 rtl/calc_port_responder.sv | 143 ++++++++++++++
 tb/tb_calc_port_responder.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_port_responder.sv
// Responder end of one calculator request/response port: takes cmd+operand1, then operand2,
// waits EXEC_CYCLES in EXEC, and issues a one-cycle registered response.
module calc_port_responder #(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [3:0]        req_cmd_in,
    input  logic [DATA_W-1:0] req_data_in,
    output logic [1:0]        out_resp,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              cmd_drop
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StOp2  = 2'd1;
    localparam logic [1:0] StExec = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    localparam logic [3:0] CmdNop = 4'd0;
    localparam logic [3:0] CmdAdd = 4'd1;
    localparam logic [3:0] CmdSub = 4'd2;
    localparam logic [3:0] CmdShl = 4'd5;
    localparam logic [3:0] CmdShr = 4'd6;

    localparam logic [1:0] RespNone = 2'd0;
    localparam logic [1:0] RespOk   = 2'd1;
    localparam logic [1:0] RespErr  = 2'd2;

    localparam logic [3:0] CntLoad = 4'(EXEC_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        resp_q, resp_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              drop_q, drop_d;

    logic [DATA_W:0]   sum;
    logic [4:0]        shamt;
    logic [1:0]        res_resp;
    logic [DATA_W-1:0] res_data;

    always_comb begin
        sum      = {1'b0, op1_q} + {1'b0, op2_q};
        shamt    = op2_q[4:0];
        res_resp = RespOk;
        res_data = '0;
        case (cmd_q)
            CmdAdd: begin
                if (sum[DATA_W]) res_resp = RespErr;
                else res_data = sum[DATA_W-1:0];
            end
            CmdSub: begin
                if (op2_q > op1_q) res_resp = RespErr;
                else res_data = op1_q - op2_q;
            end
            CmdShl:  res_data = op1_q << shamt;
            CmdShr:  res_data = op1_q >> shamt;
            default: res_resp = RespErr;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        cnt_d   = cnt_q;
        resp_d  = RespNone;
        data_d  = '0;
        drop_d  = 1'b0;
        unique case (state_q)
            StIdle, StResp: begin
                case (req_cmd_in)
                    CmdNop: state_d = StIdle;
                    CmdAdd, CmdSub, CmdShl, CmdShr: begin
                        cmd_d   = req_cmd_in;
                        op1_d   = req_data_in;
                        state_d = StOp2;
                    end
                    default: begin
                        state_d = StResp;
                        resp_d  = RespErr;
                    end
                endcase
            end
            StOp2: begin
                // Data on this edge is always operand2, even if a command rides along.
                op2_d   = req_data_in;
                cnt_d   = CntLoad;
                drop_d  = |req_cmd_in;
                state_d = StExec;
            end
            StExec: begin
                drop_d = |req_cmd_in;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    resp_d  = res_resp;
                    data_d  = res_data;
                    state_d = StResp;
                end
            end
        endcase
        busy_d = (state_d == StOp2) || (state_d == StExec);
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cmd_q   <= CmdNop;
            op1_q   <= '0;
            op2_q   <= '0;
            cnt_q   <= 4'd0;
            resp_q  <= RespNone;
            data_q  <= '0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    assign out_resp = resp_q;
    assign out_data = data_q;
    assign busy     = busy_q;
    assign cmd_drop = drop_q;

endmodule

// File: tb/tb_calc_port_responder.sv
// Directed bench: two responders (EXEC_CYCLES 1 and 4) share stimulus; each test checks one of them.
module tb_calc_port_responder;

    logic        c_clk;
    logic        reset;
    logic [3:0]  cmd;
    logic [31:0] data;
    logic [1:0]  resp1, resp4;
    logic [31:0] data1, data4;
    logic        busy1, busy4, drop1, drop4;

    int n_tests = 0;
    int n_fail  = 0;

    calc_port_responder #(.EXEC_CYCLES(1), .DATA_W(32)) u_dut1 (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (cmd),
        .req_data_in (data),
        .out_resp    (resp1),
        .out_data    (data1),
        .busy        (busy1),
        .cmd_drop    (drop1)
    );

    calc_port_responder #(.EXEC_CYCLES(4), .DATA_W(32)) u_dut4 (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (cmd),
        .req_data_in (data),
        .out_resp    (resp4),
        .out_data    (data4),
        .busy        (busy4),
        .cmd_drop    (drop4)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        cmd   = 4'd0;
        data  = 32'd0;
        step();
        reset = 1'b0;
        step();
    endtask

    // Issues one operation to the EXEC_CYCLES=1 responder and captures the response edge.
    task automatic run_op1(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                           output logic [1:0] r, output logic [31:0] d);
        cmd = c; data = a;
        step();
        cmd = 4'd0; data = b;
        step();
        data = 32'd0;
        step();
        r = resp1;
        d = data1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd = 4'd0; data = 32'd0;
        step();
        n_tests++;
        if (resp1 !== 2'd0 || data1 !== 32'd0 || busy1 !== 1'b0 || drop1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dut1: got resp=%0d data=%h busy=%b drop=%b, expected all 0",
                     resp1, data1, busy1, drop1);
        end
        n_tests++;
        if (resp4 !== 2'd0 || data4 !== 32'd0 || busy4 !== 1'b0 || drop4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dut4: got resp=%0d data=%h busy=%b drop=%b, expected all 0",
                     resp4, data4, busy4, drop4);
        end
        reset = 1'b0;
        cmd = 4'd1; data = 32'd2;
        step();
        n_tests++;
        if (busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL first_cmd_after_reset: got busy=%b, expected 1", busy1);
        end
        // Asynchronous assertion must clear outputs without a clock edge.
        reset = 1'b1;
        #2;
        n_tests++;
        if (busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b, expected 0", busy1);
        end
        cmd = 4'd0; data = 32'd0;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_add_latency();
        apply_reset();
        cmd = 4'd1; data = 32'h0000_0001;
        step();
        n_tests++;
        if (busy1 !== 1'b1 || resp1 !== 2'd0) begin
            n_fail++;
            $display("FAIL lat_e0: got busy=%b resp=%0d, expected busy=1 resp=0", busy1, resp1);
        end
        cmd = 4'd0; data = 32'h1FFF_FFFF;
        step();
        n_tests++;
        if (busy1 !== 1'b1 || resp1 !== 2'd0) begin
            n_fail++;
            $display("FAIL lat_e1: got busy=%b resp=%0d, expected busy=1 resp=0", busy1, resp1);
        end
        data = 32'd0;
        step();
        n_tests++;
        if (resp1 !== 2'd1 || data1 !== 32'h2000_0000 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_e2: got resp=%0d data=%h busy=%b, expected resp=1 data=20000000 busy=0",
                     resp1, data1, busy1);
        end
        step();
        n_tests++;
        if (resp1 !== 2'd0 || data1 !== 32'd0) begin
            n_fail++;
            $display("FAIL lat_e3: got resp=%0d data=%h, expected resp=0 data=0", resp1, data1);
        end
    endtask

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  r;
        logic [31:0] d;
    } vec_t;

    task automatic test_arith();
        vec_t v[11];
        logic [1:0]  r;
        logic [31:0] d;
        v = '{
            '{4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000},
            '{4'd1, 32'hFFFF_FFFE, 32'h0000_0001, 2'd1, 32'hFFFF_FFFF},
            '{4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0000_0000},
            '{4'd2, 32'h0000_0005, 32'h0000_0005, 2'd1, 32'h0000_0000},
            '{4'd2, 32'h0000_000A, 32'h0000_0003, 2'd1, 32'h0000_0007},
            '{4'd5, 32'h8000_0001, 32'h0000_0001, 2'd1, 32'h0000_0002},
            '{4'd6, 32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001},
            '{4'd5, 32'h0000_0003, 32'h0000_0021, 2'd1, 32'h0000_0006},
            '{4'd6, 32'h0000_00F0, 32'h0000_0024, 2'd1, 32'h0000_000F},
            '{4'd5, 32'h0000_0001, 32'h0000_0020, 2'd1, 32'h0000_0001},
            '{4'd6, 32'h0000_0001, 32'h0000_0001, 2'd1, 32'h0000_0000}
        };
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            run_op1(v[i].c, v[i].a, v[i].b, r, d);
            n_tests++;
            if (r !== v[i].r || d !== v[i].d) begin
                n_fail++;
                $display("FAIL arith_%0d (cmd %0d a=%h b=%h): got resp=%0d data=%h, expected resp=%0d data=%h",
                         i, v[i].c, v[i].a, v[i].b, r, d, v[i].r, v[i].d);
            end
        end
    endtask

    task automatic test_invalid();
        apply_reset();
        cmd = 4'd3; data = 32'hDEAD_BEEF;
        step();
        n_tests++;
        if (resp1 !== 2'd2 || data1 !== 32'd0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_cmd3: got resp=%0d data=%h busy=%b, expected resp=2 data=0 busy=0",
                     resp1, data1, busy1);
        end
        cmd = 4'd0;
        step();
        n_tests++;
        if (resp1 !== 2'd0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_clear: got resp=%0d busy=%b, expected resp=0 busy=0", resp1, busy1);
        end
        cmd = 4'd4;
        step();
        n_tests++;
        if (resp1 !== 2'd2) begin
            n_fail++;
            $display("FAIL held_cmd4_first: got resp=%0d, expected 2", resp1);
        end
        step();
        n_tests++;
        if (resp1 !== 2'd2) begin
            n_fail++;
            $display("FAIL held_cmd4_second: got resp=%0d, expected 2", resp1);
        end
        cmd = 4'd0;
        step();
        n_tests++;
        if (resp1 !== 2'd0) begin
            n_fail++;
            $display("FAIL held_cmd4_release: got resp=%0d, expected 0", resp1);
        end
        cmd = 4'd15;
        step();
        cmd = 4'd0;
        n_tests++;
        if (resp1 !== 2'd2 || data1 !== 32'd0) begin
            n_fail++;
            $display("FAIL invalid_cmd15: got resp=%0d data=%h, expected resp=2 data=0", resp1, data1);
        end
        step();
    endtask

    task automatic test_drop_op2();
        apply_reset();
        cmd = 4'd1; data = 32'd7;
        step();
        cmd = 4'd2; data = 32'd8;
        step();
        n_tests++;
        if (drop1 !== 1'b1 || busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_op2: got drop=%b busy=%b, expected drop=1 busy=1", drop1, busy1);
        end
        cmd = 4'd0; data = 32'd0;
        step();
        n_tests++;
        if (drop1 !== 1'b0 || resp1 !== 2'd1 || data1 !== 32'd15) begin
            n_fail++;
            $display("FAIL drop_op2_result: got drop=%b resp=%0d data=%h, expected drop=0 resp=1 data=f",
                     drop1, resp1, data1);
        end
        step();
    endtask

    task automatic test_drop_exec();
        int extra;
        apply_reset();
        cmd = 4'd1; data = 32'd10;
        step();
        cmd = 4'd0; data = 32'd20;
        step();
        cmd = 4'd1; data = 32'h999;
        step();
        n_tests++;
        if (drop4 !== 1'b1 || busy4 !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_exec_pulse: got drop=%b busy=%b, expected drop=1 busy=1", drop4, busy4);
        end
        cmd = 4'd0; data = 32'd0;
        step();
        n_tests++;
        if (drop4 !== 1'b0 || resp4 !== 2'd0) begin
            n_fail++;
            $display("FAIL drop_exec_once: got drop=%b resp=%0d, expected drop=0 resp=0", drop4, resp4);
        end
        step();
        n_tests++;
        if (resp4 !== 2'd0) begin
            n_fail++;
            $display("FAIL drop_exec_early: got resp=%0d at E4, expected 0", resp4);
        end
        step();
        n_tests++;
        if (resp4 !== 2'd1 || data4 !== 32'd30) begin
            n_fail++;
            $display("FAIL drop_exec_result: got resp=%0d data=%h, expected resp=1 data=1e", resp4, data4);
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (resp4 !== 2'd0 || busy4 !== 1'b0) extra++;
        end
        n_tests++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL drop_exec_no_second: got %0d active cycles after response, expected 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        apply_reset();
        cmd = 4'd1; data = 32'd100;
        step();
        cmd = 4'd0; data = 32'd1;
        step();
        data = 32'd0;
        step();
        reset = 1'b1;
        #2;
        n_tests++;
        if (busy4 !== 1'b0 || resp4 !== 2'd0 || data4 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got busy=%b resp=%0d data=%h, expected all 0",
                     busy4, resp4, data4);
        end
        step();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (resp4 !== 2'd0) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_resp: got %0d response cycles, expected 0", seen);
        end
        cmd = 4'd1; data = 32'd2;
        step();
        cmd = 4'd0; data = 32'd3;
        step();
        data = 32'd0;
        repeat (3) step();
        step();
        n_tests++;
        if (resp4 !== 2'd1 || data4 !== 32'd5) begin
            n_fail++;
            $display("FAIL reset_mid_new_add: got resp=%0d data=%h, expected resp=1 data=5", resp4, data4);
        end
        step();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        cmd = 4'd1; data = 32'd10;
        step();
        cmd = 4'd0; data = 32'd20;
        step();
        data = 32'd0;
        repeat (3) step();
        step();
        n_tests++;
        if (resp4 !== 2'd1 || data4 !== 32'd30) begin
            n_fail++;
            $display("FAIL b2b_first: got resp=%0d data=%h, expected resp=1 data=1e", resp4, data4);
        end
        cmd = 4'd1; data = 32'd40;
        step();
        n_tests++;
        if (resp4 !== 2'd0 || busy4 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: got resp=%0d busy=%b, expected resp=0 busy=1", resp4, busy4);
        end
        cmd = 4'd0; data = 32'd2;
        step();
        data = 32'd0;
        repeat (3) step();
        n_tests++;
        if (resp4 !== 2'd0) begin
            n_fail++;
            $display("FAIL b2b_early: got resp=%0d one cycle early, expected 0", resp4);
        end
        step();
        n_tests++;
        if (resp4 !== 2'd1 || data4 !== 32'd42) begin
            n_fail++;
            $display("FAIL b2b_second: got resp=%0d data=%h, expected resp=1 data=2a", resp4, data4);
        end
        step();
    endtask

    initial begin
        reset = 1'b1;
        cmd   = 4'd0;
        data  = 32'd0;
        test_reset();
        test_add_latency();
        test_arith();
        test_invalid();
        test_drop_op2();
        test_drop_exec();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
